// File: rtl/epu_pkg.sv
// Shared types and constants for the EPU layer scheduler: FSM states, error codes
// and descriptor word field positions.
package epu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_CNT,
    RD_OP,
    RD_W8,
    LAUNCH,
    WAIT,
    ADV,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_BAD_ENG   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
  localparam logic [1:0] ERR_LAYER_CNT = 2'b11;

  localparam int CNT_LSB    = 0;
  localparam int CNT_W      = 8;
  localparam int ENG_ID_LSB = 0;
  localparam int ENG_ID_W   = 3;
  localparam int NOSWAP_BIT = 8;

  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

endpackage

// File: rtl/epu_watchdog.sv
// Loadable up-counter with a terminal flag; holds at the terminal count until reloaded.
module epu_watchdog
  import epu_pkg::*;
#(
  parameter int LIMIT = 1 << 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/epu_layer_sched.sv
// Network-level sequencer: walks a layer descriptor list in SRAM, launches one engine
// per layer, waits for its finish under a watchdog and flips the ping-pong buffer.
module epu_layer_sched
  import epu_pkg::*;
#(
  parameter int NUM_ENG    = 4,
  parameter int MAX_LAYERS = 255,
  parameter int TMO_CYC    = 1 << 20
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic               desc_cs,
  output logic [31:0]        desc_addr,
  input  logic [31:0]        desc_rdata,
  output logic [NUM_ENG-1:0] eng_start,
  output logic [31:0]        eng_w8,
  input  logic [NUM_ENG-1:0] eng_finish,
  output logic               buf_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [7:0]         layer_idx
);

  state_t               state;
  logic                 rd_ph;
  logic [CNT_W-1:0]     n_cnt;
  logic [ENG_ID_W-1:0]  op_id;
  logic                 op_nosw;
  logic [NUM_ENG-1:0]   sel_mask;
  logic [CNT_W-1:0]     cnt_field;
  logic                 cnt_bad;
  logic                 id_bad;
  logic                 fin_hit;
  logic                 wd_run;
  logic                 wd_tc;

  assign cnt_field = desc_rdata[CNT_LSB +: CNT_W];
  assign cnt_bad   = (cnt_field == '0) || (32'(cnt_field) > 32'(MAX_LAYERS));
  assign id_bad    = 32'(op_id) >= 32'(NUM_ENG);
  // Only the engine we launched may advance the sequence.
  assign fin_hit   = |(eng_finish & sel_mask);
  assign wd_run    = (state == LAUNCH) || (state == WAIT);

  epu_watchdog #(
    .LIMIT(TMO_CYC)
  ) u_wd (
    .clk (clk),
    .rstn(rstn),
    .load(~wd_run),
    .en  (wd_run),
    .tc  (wd_tc)
  );

  // Each descriptor read spans two cycles: rd_ph=0 issues the address,
  // rd_ph=1 sees the returned word and consumes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_ph     <= 1'b0;
      n_cnt     <= '0;
      op_id     <= '0;
      op_nosw   <= 1'b0;
      sel_mask  <= '0;
      desc_cs   <= WRITE_DIS;
      desc_addr <= '0;
      eng_start <= '0;
      eng_w8    <= '0;
      buf_sel   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      layer_idx <= '0;
    end else begin
      eng_start <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_CNT;
            rd_ph     <= 1'b0;
            desc_cs   <= WRITE_ENB;
            desc_addr <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            layer_idx <= '0;
            buf_sel   <= 1'b0;
          end
        end
        RD_CNT: begin
          rd_ph <= ~rd_ph;
          if (rd_ph) begin
            if (cnt_bad) begin
              state    <= ERR;
              desc_cs  <= WRITE_DIS;
              err      <= 1'b1;
              err_code <= ERR_LAYER_CNT;
            end else begin
              state     <= RD_OP;
              n_cnt     <= cnt_field;
              desc_addr <= {23'd0, layer_idx, 1'b1};
            end
          end
        end
        RD_OP: begin
          rd_ph <= ~rd_ph;
          if (rd_ph) begin
            state     <= RD_W8;
            op_id     <= desc_rdata[ENG_ID_LSB +: ENG_ID_W];
            op_nosw   <= desc_rdata[NOSWAP_BIT];
            desc_addr <= {23'd0, layer_idx + 8'd1, 1'b0};
          end
        end
        RD_W8: begin
          rd_ph <= ~rd_ph;
          if (rd_ph) begin
            desc_cs <= WRITE_DIS;
            if (id_bad) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= ERR_BAD_ENG;
            end else begin
              state     <= LAUNCH;
              eng_w8    <= desc_rdata;
              eng_start <= NUM_ENG'(1) << op_id;
              sel_mask  <= NUM_ENG'(1) << op_id;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          if (fin_hit) begin
            state <= ADV;
          end else if (wd_tc) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end
        ADV: begin
          if (!op_nosw) buf_sel <= ~buf_sel;
          if (layer_idx == n_cnt - 8'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= RD_OP;
            rd_ph     <= 1'b0;
            layer_idx <= layer_idx + 8'd1;
            desc_cs   <= WRITE_ENB;
            desc_addr <= {23'd0, layer_idx + 8'd1, 1'b1};
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epu_layer_sched.sv
// Directed bench for epu_layer_sched with a one-cycle-latency descriptor SRAM model.
module tb_epu_layer_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        desc_cs;
  logic [31:0] desc_addr;
  logic [31:0] desc_rdata = '0;
  logic [3:0]  eng_start;
  logic [31:0] eng_w8;
  logic [3:0]  eng_finish = '0;
  logic        buf_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  layer_idx;

  logic [31:0] mem [0:15];
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int est_cnt = 0;
  int cs_beyond = 0;

  epu_layer_sched #(
    .NUM_ENG(4),
    .MAX_LAYERS(255),
    .TMO_CYC(64)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .desc_cs   (desc_cs),
    .desc_addr (desc_addr),
    .desc_rdata(desc_rdata),
    .eng_start (eng_start),
    .eng_w8    (eng_w8),
    .eng_finish(eng_finish),
    .buf_sel   (buf_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .layer_idx (layer_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (desc_cs) desc_rdata <= mem[desc_addr[3:0]];
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (eng_start != 4'd0) est_cnt++;
    if (desc_cs && desc_addr != 32'd0) cs_beyond++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fin(input logic [3:0] m);
    eng_finish = m;
    step();
    eng_finish = '0;
  endtask

  task automatic wait_launch(output int n);
    n = 0;
    while (eng_start == 4'd0 && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_err(output int n);
    n = 0;
    while (err == 1'b0 && n < 400) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int d0;
    int e0;
    int c0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    steps(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_cs_addr", {31'(desc_addr), desc_cs}, 0);
    check("rst_err", {29'(err_code), err, done, buf_sel}, 0);
    check("rst_idx_w8", eng_w8 | 32'(layer_idx), 0);
    rstn = 1'b1;
    step();

    // N=3, engines {1,0,1}, all swapping, finishing 50 cycles after launch
    mem[0] = 32'd3;
    mem[1] = 32'd1; mem[2] = 32'hA1B2C3D4;
    mem[3] = 32'd0; mem[4] = 32'h11223344;
    mem[5] = 32'd1; mem[6] = 32'h55667788;
    d0 = done_cnt;
    do_start();
    check("s1_busy", 32'(busy), 1);
    check("s1_rdcnt_cs", {31'(desc_addr), desc_cs}, 1);
    wait_launch(n);
    check("s1_latency", 32'(n + 1), 7);
    check("s1_l0_eng", 32'(eng_start), 32'b0010);
    check("s1_l0_w8", eng_w8, 32'hA1B2C3D4);
    check("s1_l0_buf", 32'(buf_sel), 0);
    steps(50); fin(4'b0010);
    wait_launch(n);
    check("s1_l1_eng", 32'(eng_start), 32'b0001);
    check("s1_l1_w8", eng_w8, 32'h11223344);
    check("s1_l1_buf", 32'(buf_sel), 1);
    check("s1_l1_idx", 32'(layer_idx), 1);
    do_start();
    steps(49);
    check("s1_start_ignored", 32'(layer_idx), 1);
    fin(4'b0001);
    wait_launch(n);
    check("s1_l2_eng", 32'(eng_start), 32'b0010);
    check("s1_l2_buf", 32'(buf_sel), 0);
    check("s1_l2_idx", 32'(layer_idx), 2);
    steps(50); fin(4'b0010);
    step();
    check("s1_done", 32'(done), 1);
    step();
    check("s1_busy_end", 32'(busy), 0);
    check("s1_buf_end", 32'(buf_sel), 1);
    check("s1_done_cnt", 32'(done_cnt - d0), 1);
    check("s1_err", 32'(err), 0);
    steps(2);

    // Engine id 5 is beyond NUM_ENG=4
    mem[0] = 32'd1; mem[1] = 32'd5; mem[2] = 32'hDEADBEEF;
    e0 = est_cnt;
    do_start();
    wait_err(n);
    check("s2_err", 32'(err), 1);
    check("s2_code", 32'(err_code), 32'b01);
    check("s2_busy_err_cyc", 32'(busy), 1);
    step();
    check("s2_busy_after", 32'(busy), 0);
    check("s2_err_sticky", 32'(err), 1);
    check("s2_no_launch", 32'(est_cnt - e0), 0);
    steps(2);

    // Engine never finishes: timeout 64 cycles after the launch cycle
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'h0000BEEF;
    do_start();
    check("s3_err_cleared", 32'(err), 0);
    wait_launch(n);
    check("s3_eng", 32'(eng_start), 32'b0100);
    wait_err(n);
    check("s3_tmo_cycles", 32'(n), 64);
    check("s3_code", 32'(err_code), 32'b10);
    steps(3);

    // Foreign finish ignored; no-swap layer; finish coincides with watchdog terminal
    mem[0] = 32'd2;
    mem[1] = 32'h100; mem[2] = 32'h0F0F0F0F;
    mem[3] = 32'd0;   mem[4] = 32'hF0F0F0F0;
    d0 = done_cnt;
    e0 = est_cnt;
    do_start();
    wait_launch(n);
    check("s4_l0_eng", 32'(eng_start), 32'b0001);
    steps(10); fin(4'b0100); steps(3);
    check("s4_foreign_idx", 32'(layer_idx), 0);
    check("s4_foreign_nolaunch", 32'(est_cnt - e0), 1);
    fin(4'b0001);
    wait_launch(n);
    check("s4_l1_idx", 32'(layer_idx), 1);
    check("s4_l1_eng", 32'(eng_start), 32'b0001);
    check("s4_noswap_buf", 32'(buf_sel), 0);
    steps(63); fin(4'b0001);
    step();
    check("s4_finish_wins_done", 32'(done), 1);
    check("s4_finish_wins_err", 32'(err), 0);
    step();
    check("s4_buf_end", 32'(buf_sel), 1);
    steps(2);

    // Reset during WAIT of layer 1, then a clean rerun
    mem[0] = 32'd2;
    mem[1] = 32'd1; mem[2] = 32'h12345678;
    mem[3] = 32'd1; mem[4] = 32'h9ABCDEF0;
    d0 = done_cnt;
    do_start();
    wait_launch(n);
    steps(20); fin(4'b0010);
    wait_launch(n);
    check("s5_pre_buf", 32'(buf_sel), 1);
    steps(5);
    rstn = 1'b0;
    #1;
    check("s5_rst_busy", 32'(busy), 0);
    check("s5_rst_buf_idx", {23'(layer_idx), buf_sel}, 0);
    check("s5_rst_w8", eng_w8, 0);
    check("s5_rst_cs_start", {27'(eng_start), desc_cs}, 0);
    step();
    rstn = 1'b1;
    step();
    check("s5_no_done", 32'(done_cnt - d0), 0);
    do_start();
    wait_launch(n);
    check("s5_re_latency", 32'(n + 1), 7);
    check("s5_re_idx", 32'(layer_idx), 0);
    check("s5_re_buf", 32'(buf_sel), 0);
    steps(20); fin(4'b0010);
    wait_launch(n);
    steps(20); fin(4'b0010);
    steps(3);
    check("s5_re_done", 32'(done_cnt - d0), 1);
    steps(2);

    // Bad layer counts: 0 and 256 (which truncates to 0 in the count field)
    c0 = cs_beyond;
    mem[0] = 32'd0;
    do_start();
    wait_err(n);
    check("s6_n0_cycles", 32'(n), 2);
    check("s6_n0_code", 32'(err_code), 32'b11);
    steps(3);
    mem[0] = 32'h100;
    do_start();
    wait_err(n);
    check("s6_n256_code", 32'(err_code), 32'b11);
    steps(3);
    check("s6_cs_word0_only", 32'(cs_beyond - c0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
